// File: rtl/unidade_controle_multiciclo_if.sv
// Memory-side handshake bundle of the multicycle controller: instruction fetch
// and data access requests, their ready strobes, and the latched instruction word.
interface unidade_controle_multiciclo_if;
   logic [31:0] instr;
   logic        imem_ready;
   logic        dmem_ready;
   logic        imem_req;
   logic        ir_write;
   logic        dmem_read;
   logic        dmem_write;

   modport master (
      input  instr, imem_ready, dmem_ready,
      output imem_req, ir_write, dmem_read, dmem_write
   );

   modport slave (
      output instr, imem_ready, dmem_ready,
      input  imem_req, ir_write, dmem_read, dmem_write
   );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the shared add/sub ALU datapath (RV64 add/sub/ld/sd/beq/ecall).
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | instruction request outstanding, IR loads on imem_ready
// DECODE | classify instruction, halt on ecall or unsupported encoding
// EXEC   | ALU address/compare/arith cycle; beq retires here
// MEM    | data access outstanding; sd retires on dmem_ready
// WB     | register write-back and PC+4, retires add/sub/ld
// HALTED | terminal until reset
module unidade_controle_multiciclo #(
   parameter int COUNT_W    = 32,
   parameter int WAIT_LIMIT = 255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       alu_zero,
   unidade_controle_multiciclo_if.master mem,
   output logic [1:0]                 OP_MEM_I,
   output logic                       ADD_SUB,
   output logic [1:0]                 imm_sel,
   output logic                       reg_write,
   output logic                       wb_sel,
   output logic                       pc_write,
   output logic                       pc_src,
   output logic                       busy,
   output logic                       halted,
   output logic                       illegal,
   output logic                       bus_err,
   output logic [COUNT_W-1:0]         instr_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALTED = 3'd6;

   localparam logic [2:0] C_ADD   = 3'd0;
   localparam logic [2:0] C_SUB   = 3'd1;
   localparam logic [2:0] C_LD    = 3'd2;
   localparam logic [2:0] C_SD    = 3'd3;
   localparam logic [2:0] C_BEQ   = 3'd4;
   localparam logic [2:0] C_ECALL = 3'd5;
   localparam logic [2:0] C_ILL   = 3'd6;

   // Timeout fires on the wait cycle that would bring the counter to WAIT_LIMIT.
   localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

   logic [2:0]         state_q, state_d;
   logic [2:0]         cls_q, cls_d;
   logic [2:0]         dec_cls;
   logic [15:0]        wait_q, wait_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               illegal_q, illegal_d;
   logic               bus_err_q, bus_err_d;
   logic               imem_req_c, ir_write_c, dmem_read_c, dmem_write_c;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   assign opcode = mem.instr[6:0];
   assign funct3 = mem.instr[14:12];
   assign funct7 = mem.instr[31:25];

   always_comb begin
      dec_cls = C_ILL;
      if (mem.instr == 32'h0000_0073) begin
         dec_cls = C_ECALL;
      end else begin
         case (opcode)
            7'b0110011: begin
               if (funct3 == 3'b000 && funct7 == 7'b0000000)      dec_cls = C_ADD;
               else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_cls = C_SUB;
            end
            7'b0000011: if (funct3 == 3'b011) dec_cls = C_LD;
            7'b0100011: if (funct3 == 3'b011) dec_cls = C_SD;
            7'b1100011: if (funct3 == 3'b000) dec_cls = C_BEQ;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      wait_d    = wait_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_FETCH: begin
            if (mem.imem_ready) begin
               state_d = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               state_d   = S_HALTED;
               bus_err_d = 1'b1;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         S_DECODE: begin
            cls_d = dec_cls;
            if (dec_cls == C_ECALL) begin
               state_d = S_HALTED;
            end else if (dec_cls == C_ILL) begin
               state_d   = S_HALTED;
               illegal_d = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cls_q == C_BEQ) begin
               state_d = S_FETCH;
               wait_d  = '0;
               cnt_d   = cnt_q + COUNT_W'(1);
            end else if (cls_q == C_LD || cls_q == C_SD) begin
               state_d = S_MEM;
               wait_d  = '0;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (mem.dmem_ready) begin
               if (cls_q == C_SD) begin
                  state_d = S_FETCH;
                  wait_d  = '0;
                  cnt_d   = cnt_q + COUNT_W'(1);
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d   = S_HALTED;
               bus_err_d = 1'b1;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            wait_d  = '0;
            cnt_d   = cnt_q + COUNT_W'(1);
         end
         S_HALTED: ;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cls_q     <= C_ADD;
         wait_q    <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         wait_q    <= wait_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      OP_MEM_I     = 2'd0;
      ADD_SUB      = 1'b0;
      imm_sel      = 2'd0;
      imem_req_c   = 1'b0;
      ir_write_c   = 1'b0;
      dmem_read_c  = 1'b0;
      dmem_write_c = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            ir_write_c = mem.imem_ready;
         end
         S_EXEC: begin
            case (cls_q)
               C_SUB: ADD_SUB = 1'b1;
               C_LD:  OP_MEM_I = 2'd2;
               C_SD: begin
                  OP_MEM_I = 2'd2;
                  imm_sel  = 2'd1;
               end
               C_BEQ: begin
                  ADD_SUB  = 1'b1;
                  imm_sel  = 2'd2;
                  pc_write = 1'b1;
                  pc_src   = alu_zero;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            OP_MEM_I     = 2'd2;
            imm_sel      = (cls_q == C_SD) ? 2'd1 : 2'd0;
            dmem_read_c  = (cls_q == C_LD);
            dmem_write_c = (cls_q == C_SD);
            pc_write     = (cls_q == C_SD) && mem.dmem_ready;
         end
         S_WB: begin
            reg_write = 1'b1;
            wb_sel    = (cls_q == C_LD);
            pc_write  = 1'b1;
         end
         default: ;
      endcase
   end

   assign mem.imem_req   = imem_req_c;
   assign mem.ir_write   = ir_write_c;
   assign mem.dmem_read  = dmem_read_c;
   assign mem.dmem_write = dmem_write_c;
   assign busy           = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign halted         = (state_q == S_HALTED);
   assign illegal        = illegal_q;
   assign bus_err        = bus_err_q;
   assign instr_count    = cnt_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle controller: a table of single-instruction runs
// plus hand sequences for wait timeout, illegal/ecall halt and mid-access reset.
module tb_unidade_controle_multiciclo;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_LD    = 32'h0000B183;
   localparam logic [31:0] I_SD    = 32'h0030B023;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_ECALL = 32'h00000073;
   localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        alu_zero;
   logic [1:0]  OP_MEM_I;
   logic        ADD_SUB;
   logic [1:0]  imm_sel;
   logic        reg_write, wb_sel, pc_write, pc_src;
   logic        busy, halted, illegal, bus_err;
   logic [31:0] instr_count;

   int checks = 0;
   int errors = 0;

   unidade_controle_multiciclo_if bus();

   unidade_controle_multiciclo #(.COUNT_W(32), .WAIT_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_zero(alu_zero), .mem(bus),
      .OP_MEM_I(OP_MEM_I), .ADD_SUB(ADD_SUB), .imm_sel(imm_sel),
      .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
      .busy(busy), .halted(halted), .illegal(illegal), .bus_err(bus_err),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        az;
      int          dly;
      int          cyc;
      logic [1:0]  op;
      logic        as;
      logic [1:0]  ims;
      logic        rw;
      logic        wbs;
      logic        dr;
      logic        dw;
      logic        psrc;
      int          memc;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Runs one instruction from its FETCH cycle to retirement; DUT must be about to sit in FETCH.
   task automatic run_vec(input int idx, input vec_t v);
      int         pcw_cyc = 0;
      int         memc    = 0;
      logic       rw = 0, dr = 0, dw = 0, wbs = 0, psrc = 0, irw = 0, bsy = 0, as = 0;
      logic [1:0] op = 0, ims = 0;
      logic [31:0] c0;
      string      tag;
      c0 = instr_count;
      tag = $sformatf("vec%0d", idx);
      bus.instr      = v.instr;
      alu_zero       = v.az;
      bus.imem_ready = 1'b1;
      bus.dmem_ready = (v.dly == 0);
      for (int n = 1; n <= 14 && pcw_cyc == 0; n++) begin
         @(negedge clk);
         start = 1'b0;
         bus.dmem_ready = (memc >= v.dly);
         #1;
         if (n == 1) begin irw = bus.ir_write; bsy = busy; end
         if (n == 3) begin op = OP_MEM_I; as = ADD_SUB; ims = imm_sel; end
         if (reg_write) begin rw = 1'b1; wbs = wb_sel; end
         if (bus.dmem_read)  dr = 1'b1;
         if (bus.dmem_write) dw = 1'b1;
         if (bus.dmem_read || bus.dmem_write) memc++;
         if (pc_write) begin pcw_cyc = n; psrc = pc_src; end
      end
      chk({tag, " ir_write"}, 64'(irw), 64'(1'b1));
      chk({tag, " busy"}, 64'(bsy), 64'(1'b1));
      chk({tag, " cycles"}, 64'(pcw_cyc), 64'(v.cyc));
      chk({tag, " OP_MEM_I"}, 64'(op), 64'(v.op));
      chk({tag, " ADD_SUB"}, 64'(as), 64'(v.as));
      chk({tag, " imm_sel"}, 64'(ims), 64'(v.ims));
      chk({tag, " reg_write"}, 64'(rw), 64'(v.rw));
      chk({tag, " wb_sel"}, 64'(wbs), 64'(v.wbs));
      chk({tag, " dmem_read"}, 64'(dr), 64'(v.dr));
      chk({tag, " dmem_write"}, 64'(dw), 64'(v.dw));
      chk({tag, " pc_src"}, 64'(psrc), 64'(v.psrc));
      chk({tag, " mem_cycles"}, 64'(memc), 64'(v.memc));
      bus.imem_ready = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " instr_count"}, 64'(instr_count), 64'(c0 + 32'd1));
      bus.imem_ready = 1'b1;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n_req;
      int n_rd;
      logic [31:0] total;

      //                 instr  az  dly cyc op  as ims rw wbs dr dw psrc memc
      vecs[0] = '{I_ADD, 1'b0, 0, 4, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[1] = '{I_SUB, 1'b0, 0, 4, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[2] = '{I_LD,  1'b0, 3, 8, 2'd2, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4};
      vecs[3] = '{I_BEQ, 1'b1, 0, 3, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[4] = '{I_BEQ, 1'b0, 0, 3, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[5] = '{I_SD,  1'b0, 0, 4, 2'd2, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
      vecs[6] = '{I_SD,  1'b0, 2, 6, 2'd2, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3};

      rst_n = 1'b0;
      start = 1'b0;
      alu_zero = 1'b0;
      bus.instr = '0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      #3;
      chk("reset outputs",
          64'({OP_MEM_I, ADD_SUB, imm_sel, bus.ir_write, bus.imem_req, bus.dmem_read,
               bus.dmem_write, reg_write, wb_sel, pc_write, pc_src, busy, halted,
               illegal, bus_err}), 64'(0));
      chk("reset instr_count", 64'(instr_count), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("idle not busy", 64'(busy), 64'(0));

      // Table: back-to-back instructions, counter accumulates across runs.
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
      total = 32'd7;
      chk("table total count", 64'(instr_count), 64'(total));

      // Unsupported encoding halts with illegal, start then ignored.
      bus.instr = I_BAD;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("illegal halted", 64'(halted), 64'(1));
      chk("illegal flag", 64'(illegal), 64'(1));
      chk("illegal busy", 64'(busy), 64'(0));
      chk("illegal bus_err", 64'(bus_err), 64'(0));
      chk("illegal count", 64'(instr_count), 64'(total));
      start = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("halted ignores start", 64'({halted, bus.imem_req, busy}), 64'(3'b100));
      start = 1'b0;

      // Fetch timeout: imem_ready stuck low.
      reset_dut();
      start = 1'b1;
      bus.imem_ready = 1'b0;
      n_req = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (halted) break;
         if (bus.imem_req) n_req++;
      end
      chk("fetch timeout req cycles", 64'(n_req), 64'(4));
      chk("fetch timeout halted", 64'(halted), 64'(1));
      chk("fetch timeout bus_err", 64'(bus_err), 64'(1));
      chk("fetch timeout req dropped", 64'(bus.imem_req), 64'(0));
      chk("fetch timeout illegal", 64'(illegal), 64'(0));
      chk("fetch timeout count", 64'(instr_count), 64'(0));

      // Ready on the limit cycle wins.
      reset_dut();
      start = 1'b1;
      bus.instr = I_ADD;
      bus.imem_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      bus.imem_ready = 1'b1;
      #1;
      chk("limit cycle ir_write", 64'(bus.ir_write), 64'(1));
      @(negedge clk);
      #1;
      chk("limit cycle no error", 64'({halted, bus_err, busy}), 64'(3'b001));
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("limit cycle add wb", 64'({reg_write, pc_write}), 64'(2'b11));
      bus.instr = I_LD;
      bus.dmem_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("count before reset", 64'(instr_count), 64'(1));

      // Reset in the middle of an ld data access.
      n_rd = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         #1;
         if (bus.dmem_read) begin n_rd = 1; break; end
      end
      chk("ld reached MEM", 64'(n_rd), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset drops dmem_read", 64'(bus.dmem_read), 64'(0));
      chk("reset mid MEM idle", 64'({busy, halted, reg_write, pc_write}), 64'(0));
      chk("reset mid MEM count", 64'(instr_count), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // ecall after restart halts cleanly.
      @(negedge clk);
      start = 1'b1;
      bus.instr = I_ECALL;
      bus.imem_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("ecall halted", 64'(halted), 64'(1));
      chk("ecall flags", 64'({illegal, bus_err}), 64'(0));
      chk("ecall count", 64'(instr_count), 64'(0));

      // Data timeout on ld.
      reset_dut();
      start = 1'b1;
      bus.instr = I_LD;
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b0;
      n_rd = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (halted) break;
         if (bus.dmem_read) n_rd++;
      end
      chk("mem timeout read cycles", 64'(n_rd), 64'(4));
      chk("mem timeout flags", 64'({halted, bus_err, illegal}), 64'(3'b110));
      chk("mem timeout read dropped", 64'(bus.dmem_read), 64'(0));
      chk("mem timeout count", 64'(instr_count), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
